// File: rtl/bomb_timer.sv
// Countdown bomb timer with BCD seconds, level-based load time,
// strike penalties, pause and expiry.
module bomb_timer #(
   parameter int TICK_DIV    = 50000000,
   parameter int LEVEL_W     = 8,
   parameter int PENALTY_SEC = 10,
   parameter int MIN_SEC     = 30
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LEVEL_W-1:0] game_level,
   input  logic               load,
   input  logic               start,
   input  logic               pause,
   input  logic               strike,
   output logic [3:0]         value_three,
   output logic [3:0]         value_two,
   output logic [3:0]         value_one,
   output logic               running,
   output logic               expired,
   output logic               tick
);

   localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam int PEN1 = PENALTY_SEC + 1;

   localparam logic [11:0] PEN_BCD = {
      4'(PENALTY_SEC / 100),
      4'((PENALTY_SEC / 10) % 10),
      4'(PENALTY_SEC % 10)};
   localparam logic [11:0] PEN1_BCD = {
      4'((PEN1 / 100) % 10),
      4'((PEN1 / 10) % 10),
      4'(PEN1 % 10)};
   localparam logic PEN1_SAT = (PEN1 > 999);
   localparam logic [11:0] MIN_BCD = {
      4'(MIN_SEC / 100),
      4'((MIN_SEC / 10) % 10),
      4'(MIN_SEC % 10)};

   typedef enum logic [2:0] {
      IDLE,
      LOADED,
      RUNNING,
      PAUSED,
      EXPIRED
   } state_t;

   state_t           state, n_state;
   logic [11:0]      dig, n_dig;
   logic [DIV_W-1:0] div, n_div;
   logic             n_tick;
   logic             wrap;
   logic             sub_en;
   logic             sub_sat;
   logic [11:0]      sub_b;
   logic [12:0]      diff;
   logic [11:0]      sub_res;

   // Digit-wise BCD subtract; bit 12 is the final borrow (underflow).
   function automatic logic [12:0] bcd_sub(
      input logic [11:0] a,
      input logic [11:0] b
   );
      logic [11:0] r;
      logic        bw;
      logic [4:0]  d;
      bw = 1'b0;
      r  = '0;
      for (int i = 0; i < 3; i++) begin
         d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, bw};
         if (d[4]) begin
            d  = d + 5'd10;
            bw = 1'b1;
         end else begin
            bw = 1'b0;
         end
         r[4*i +: 4] = d[3:0];
      end
      return {bw, r};
   endfunction

   function automatic logic [11:0] level_bcd(
      input logic [LEVEL_W-1:0] lv
   );
      logic [LEVEL_W+3:0] lx;
      logic [11:0]        v;
      lx = {4'b0, lv};
      case (lx)
         (LEVEL_W+4)'(0):  v = 12'h200;
         (LEVEL_W+4)'(1):  v = 12'h150;
         (LEVEL_W+4)'(2):  v = 12'h100;
         (LEVEL_W+4)'(3):  v = 12'h090;
         (LEVEL_W+4)'(4):  v = 12'h080;
         (LEVEL_W+4)'(5):  v = 12'h070;
         (LEVEL_W+4)'(6):  v = 12'h060;
         (LEVEL_W+4)'(7):  v = 12'h050;
         (LEVEL_W+4)'(8):  v = 12'h045;
         (LEVEL_W+4)'(9):  v = 12'h040;
         (LEVEL_W+4)'(10): v = 12'h035;
         default:          v = MIN_BCD;
      endcase
      return v;
   endfunction

   assign wrap = (div == DIV_LAST);

   // Strike on a wrap edge folds the one-second decrement into the penalty.
   always_comb begin
      sub_en  = 1'b0;
      sub_sat = 1'b0;
      sub_b   = '0;
      if (state == RUNNING) begin
         if (strike && wrap) begin
            sub_en  = 1'b1;
            sub_b   = PEN1_BCD;
            sub_sat = PEN1_SAT;
         end else if (strike) begin
            sub_en = 1'b1;
            sub_b  = PEN_BCD;
         end else if (wrap) begin
            sub_en = 1'b1;
            sub_b  = 12'h001;
         end
      end else if (state == PAUSED && strike) begin
         sub_en = 1'b1;
         sub_b  = PEN_BCD;
      end
   end

   assign diff    = bcd_sub(dig, sub_b);
   assign sub_res = (sub_sat || diff[12]) ? 12'h000 : diff[11:0];

   always_comb begin
      n_state = state;
      n_dig   = dig;
      n_div   = div;
      n_tick  = 1'b0;
      if (load) begin
         n_state = LOADED;
         n_dig   = level_bcd(game_level);
         n_div   = '0;
      end else begin
         unique case (state)
            IDLE: begin
            end
            LOADED: begin
               if (start)
                  n_state = (dig == 12'h000) ? EXPIRED : RUNNING;
            end
            RUNNING: begin
               n_div  = wrap ? '0 : div + 1'b1;
               n_tick = wrap;
               if (sub_en)
                  n_dig = sub_res;
               if (sub_en && sub_res == 12'h000)
                  n_state = EXPIRED;
               else if (pause)
                  n_state = PAUSED;
            end
            PAUSED: begin
               if (sub_en)
                  n_dig = sub_res;
               if (sub_en && sub_res == 12'h000)
                  n_state = EXPIRED;
               else if (!pause)
                  n_state = RUNNING;
            end
            EXPIRED: begin
               n_dig = 12'h000;
            end
            default: begin
               n_state = IDLE;
               n_dig   = 12'h000;
               n_div   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         dig     <= '0;
         div     <= '0;
         tick    <= 1'b0;
         running <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= n_state;
         dig     <= n_dig;
         div     <= n_div;
         tick    <= n_tick;
         running <= (n_state == RUNNING);
         expired <= (n_state == EXPIRED);
      end
   end

   assign value_three = dig[11:8];
   assign value_two   = dig[7:4];
   assign value_one   = dig[3:0];

endmodule
